// File: rtl/seg_scan_driver_if.sv
// Display-side bundle for seg_scan_driver: BCD/flag inputs from the clock logic
// and the registered anode/cathode drive back out.
interface seg_scan_driver_if;
  logic        enable;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  blink_mask;
  logic        lz_blank;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  modport master (
    output enable, digits, dp_in, blink_mask, lz_blank,
    input  anode, seg, dp, digit_sel, frame_tick
  );

  modport slave (
    input  enable, digits, dp_in, blink_mask, lz_blank,
    output anode, seg, dp, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode 7-segment scanner: prescaled digit rotation, per-digit
// dead time, frame-latched BCD decode, leading-zero suppression and blinking.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input logic               clk,
  input logic               rst,
  seg_scan_driver_if.slave  bus
);
  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0: dec7 = 7'h40;
      4'd1: dec7 = 7'h79;
      4'd2: dec7 = 7'h24;
      4'd3: dec7 = 7'h30;
      4'd4: dec7 = 7'h19;
      4'd5: dec7 = 7'h12;
      4'd6: dec7 = 7'h02;
      4'd7: dec7 = 7'h78;
      4'd8: dec7 = 7'h00;
      4'd9: dec7 = 7'h10;
      default: dec7 = 7'h3F;
    endcase
  endfunction

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic          wrapped;
  logic [15:0]   f_digits;
  logic [3:0]    f_dp, f_mask;
  logic          f_lz;

  logic [3:0] anode_q;
  logic [6:0] seg_q;
  logic       dp_q;
  logic [1:0] sel_q;
  logic       tick_q;

  logic       last, wrap, lit, blink;
  logic [3:0] nib;
  logic [6:0] seg_c;
  logic       dp_c;

  assign last = (cnt == CNT_MAX);
  assign wrap = last && (idx == 2'd3);
  assign nib  = f_digits[{idx, 2'b00} +: 4];

  // cnt == 0 is always dark so adjacent digits never overlap, even with no dead time
  always_comb begin
    lit   = bus.enable && (cnt != '0) && !(cnt < BLANK);
    blink = phase && f_mask[idx];
    seg_c = dec7(nib);
    if (blink || (f_lz && idx == 2'd3 && nib == 4'd0)) seg_c = 7'h7F;
    dp_c  = ~f_dp[idx] | blink;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      idx      <= '0;
      fcnt     <= '0;
      phase    <= 1'b0;
      wrapped  <= 1'b0;
      f_digits <= '0;
      f_dp     <= '0;
      f_mask   <= '0;
      f_lz     <= 1'b0;
      anode_q  <= 4'hF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      sel_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      anode_q <= lit ? ~(4'b0001 << idx) : 4'hF;
      seg_q   <= lit ? seg_c : 7'h7F;
      dp_q    <= lit ? dp_c : 1'b1;
      sel_q   <= idx;
      // the tick lines up with the first output cycle of the new frame
      tick_q  <= bus.enable && wrapped;
      if (bus.enable) begin
        wrapped <= wrap;
        cnt     <= last ? '0 : cnt + 1'b1;
        if (last) idx <= idx + 1'b1;
        if (wrap) begin
          f_digits <= bus.digits;
          f_dp     <= bus.dp_in;
          f_mask   <= bus.blink_mask;
          f_lz     <= bus.lz_blank;
          if (fcnt == FRM_MAX) begin
            fcnt  <= '0;
            phase <= ~phase;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_tick = tick_q;
endmodule
